// File: rtl/flight_sequencer.sv
// Mission phase controller: countdown, ascent, gimbal hand-off, burnout/coast and safing.
// Mission-elapsed time is kept in whole seconds from liftoff (ASCENT entry).
module flight_sequencer #(
    parameter int unsigned  N             = 64,
    parameter int unsigned  TICKS_PER_SEC = 50000,
    parameter int unsigned  COUNTDOWN_S   = 3,
    parameter logic [N-1:0] GIMBAL_HEIGHT = N'(64'd30_000_000_000_000)
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         launch_req,
    input  logic         abort,
    input  logic [N-1:0] burntime,
    input  logic [N-1:0] height,
    output logic         launch_ack,
    output logic         engine_on,
    output logic         start_integration,
    output logic         gimbal_enable,
    output logic [2:0]   phase,
    output logic [N-1:0] met_s,
    output logic         sec_tick,
    output logic         event_valid,
    output logic [2:0]   event_code
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StIgnition = 3'd1,
        StAscent   = 3'd2,
        StGimbal   = 3'd3,
        StCoast    = 3'd4,
        StSafe     = 3'd5
    } phase_e;

    localparam int unsigned   TW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned   CW        = $clog2(COUNTDOWN_S + 1);
    localparam logic [TW-1:0] TickLast  = TW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] CountInit = CW'(COUNTDOWN_S);

    phase_e        phase_q, phase_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [CW-1:0] countdown_q, countdown_d;
    logic [N-1:0]  burn_q, burn_d;
    logic [N-1:0]  met_q, met_d;
    logic          ack_q, ack_d;
    logic          sec_q, sec_d;
    logic          ev_valid_q, ev_valid_d;
    logic [2:0]    ev_code_q, ev_code_d;
    logic          engine_q, engine_d;
    logic          integ_q, integ_d;
    logic          gimbal_q, gimbal_d;
    logic          active;
    logic          wrap;

    assign active = (phase_q == StIgnition) || (phase_q == StAscent) ||
                    (phase_q == StGimbal)   || (phase_q == StCoast);
    assign wrap   = active && (tick_q == TickLast);

    always_comb begin
        phase_d     = phase_q;
        tick_d      = '0;
        countdown_d = countdown_q;
        burn_d      = burn_q;
        met_d       = met_q;
        ack_d       = 1'b0;
        sec_d       = 1'b0;
        // Abort wins over every other transition and freezes the mission clock.
        if (active && abort) begin
            phase_d = StSafe;
        end else begin
            if (active) begin
                tick_d = wrap ? '0 : tick_q + TW'(1);
                sec_d  = wrap;
            end
            if (active && phase_q != StIgnition && wrap && met_q != '1) begin
                met_d = met_q + N'(1);
            end
            unique case (phase_q)
                StIdle: begin
                    met_d = '0;
                    if (launch_req && !abort) begin
                        phase_d     = StIgnition;
                        ack_d       = 1'b1;
                        burn_d      = burntime;
                        countdown_d = CountInit;
                    end
                end
                StIgnition: begin
                    if (wrap) begin
                        countdown_d = countdown_q - CW'(1);
                        if (countdown_q == CW'(1)) begin
                            phase_d = StAscent;
                            met_d   = '0;
                        end
                    end
                end
                StAscent: begin
                    if (met_q >= burn_q) begin
                        phase_d = StCoast;
                    end else if (height >= GIMBAL_HEIGHT) begin
                        phase_d = StGimbal;
                    end
                end
                StGimbal: begin
                    if (met_q >= burn_q) begin
                        phase_d = StCoast;
                    end
                end
                StCoast: phase_d = phase_q;
                StSafe: begin
                    if (!abort && !launch_req) begin
                        phase_d = StIdle;
                        met_d   = '0;
                    end
                end
                default: phase_d = StIdle;
            endcase
        end
        engine_d   = (phase_d == StIgnition) || (phase_d == StAscent) || (phase_d == StGimbal);
        integ_d    = (phase_d == StAscent) || (phase_d == StGimbal) || (phase_d == StCoast);
        gimbal_d   = (phase_d == StGimbal);
        ev_valid_d = (phase_d != phase_q);
        ev_code_d  = ev_valid_d ? phase_d : ev_code_q;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            phase_q     <= StIdle;
            tick_q      <= '0;
            countdown_q <= '0;
            burn_q      <= '0;
            met_q       <= '0;
            ack_q       <= 1'b0;
            sec_q       <= 1'b0;
            ev_valid_q  <= 1'b0;
            ev_code_q   <= 3'd0;
            engine_q    <= 1'b0;
            integ_q     <= 1'b0;
            gimbal_q    <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            tick_q      <= tick_d;
            countdown_q <= countdown_d;
            burn_q      <= burn_d;
            met_q       <= met_d;
            ack_q       <= ack_d;
            sec_q       <= sec_d;
            ev_valid_q  <= ev_valid_d;
            ev_code_q   <= ev_code_d;
            engine_q    <= engine_d;
            integ_q     <= integ_d;
            gimbal_q    <= gimbal_d;
        end
    end

    assign launch_ack        = ack_q;
    assign engine_on         = engine_q;
    assign start_integration = integ_q;
    assign gimbal_enable     = gimbal_q;
    assign phase             = phase_q;
    assign met_s             = met_q;
    assign sec_tick          = sec_q;
    assign event_valid       = ev_valid_q;
    assign event_code        = ev_code_q;

endmodule

// File: tb/tb_flight_sequencer.sv
// Bench for flight_sequencer: directed mission scenarios plus randomized traffic
// compared against an elapsed-cycle reference model.
module tb_flight_sequencer;

    localparam int TPS = 4;
    localparam int CD  = 2;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        launch_req = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] burntime = '0;
    logic [63:0] height = '0;
    logic        launch_ack, engine_on, start_integration, gimbal_enable;
    logic        sec_tick, event_valid;
    logic [2:0]  phase, event_code;
    logic [63:0] met_s;
    logic [11:0] dut_vec;

    int checks = 0;
    int errors = 0;

    flight_sequencer #(
        .N             (64),
        .TICKS_PER_SEC (TPS),
        .COUNTDOWN_S   (CD),
        .GIMBAL_HEIGHT (64'd100)
    ) dut (
        .clk               (clk),
        .resetb            (resetb),
        .launch_req        (launch_req),
        .abort             (abort),
        .burntime          (burntime),
        .height            (height),
        .launch_ack        (launch_ack),
        .engine_on         (engine_on),
        .start_integration (start_integration),
        .gimbal_enable     (gimbal_enable),
        .phase             (phase),
        .met_s             (met_s),
        .sec_tick          (sec_tick),
        .event_valid       (event_valid),
        .event_code        (event_code)
    );

    always #5 clk = ~clk;

    assign dut_vec = {launch_ack, engine_on, start_integration, gimbal_enable, phase,
                      sec_tick, event_valid, event_code};

    // Reference model: time is the count of clock edges since ignition; seconds and
    // liftoff follow from plain division of that count.
    int          m_ph = 0;
    int          m_cyc = 0;
    logic [63:0] m_burn = '0;
    logic [63:0] m_met = '0;
    logic        m_ack = 1'b0;
    logic        m_sec = 1'b0;
    logic        m_evv = 1'b0;
    logic [2:0]  m_evc = 3'd0;

    task automatic model_reset();
        m_ph = 0; m_cyc = 0; m_burn = '0; m_met = '0;
        m_ack = 1'b0; m_sec = 1'b0; m_evv = 1'b0; m_evc = 3'd0;
    endtask

    task automatic model_step();
        int nph;
        nph   = m_ph;
        m_ack = 1'b0;
        m_sec = 1'b0;
        if (m_ph >= 1 && m_ph <= 4 && abort) begin
            nph = 5;
        end else begin
            case (m_ph)
                0: begin
                    m_met = '0;
                    if (launch_req && !abort) begin
                        nph = 1; m_ack = 1'b1; m_burn = burntime; m_cyc = 0;
                    end
                end
                5: if (!abort && !launch_req) begin nph = 0; m_met = '0; end
                default: begin
                    if (m_ph == 2) begin
                        if (m_met >= m_burn) nph = 4;
                        else if (height >= 64'd100) nph = 3;
                    end else if (m_ph == 3 && m_met >= m_burn) begin
                        nph = 4;
                    end
                    m_cyc++;
                    m_sec = ((m_cyc % TPS) == 0);
                    if (m_cyc >= CD * TPS) begin
                        m_met = 64'((m_cyc - CD * TPS) / TPS);
                        if (m_ph == 1) nph = 2;
                    end
                end
            endcase
        end
        m_evv = (nph != m_ph);
        if (m_evv) m_evc = 3'(nph);
        m_ph = nph;
    endtask

    always @(posedge clk or negedge resetb) begin
        if (!resetb) model_reset();
        else model_step();
    end

    function automatic logic [11:0] exp_vec();
        logic [2:0] p;
        p = 3'(m_ph);
        return {m_ack, (m_ph >= 1 && m_ph <= 3), (m_ph >= 2 && m_ph <= 4), (m_ph == 3), p,
                m_sec, m_evv, m_evc};
    endfunction

    task automatic do_reset();
        resetb = 1'b0; launch_req = 1'b0; abort = 1'b0; burntime = '0; height = '0;
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (phase !== 3'd0) begin
            errors++; $display("FAIL reset_phase got %0d want 0", phase);
        end
        checks++;
        if (dut_vec !== 12'd0) begin
            errors++; $display("FAIL reset_outputs got %b want 0", dut_vec);
        end
        checks++;
        if (met_s !== 64'd0) begin
            errors++; $display("FAIL reset_met got %0d want 0", met_s);
        end
        resetb = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_nominal();
        int n;
        bit saw_gimbal;
        do_reset();
        height = 64'd0; burntime = 64'd5; launch_req = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        checks++;
        if (launch_ack !== 1'b1 || phase !== 3'd1) begin
            errors++; $display("FAIL nominal_ack got ack=%b phase=%0d want ack=1 phase=1",
                               launch_ack, phase);
        end
        n = 0;
        while (phase !== 3'd2 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL nominal_ascent_latency got %0d want 8", n);
        end
        saw_gimbal = 1'b0; n = 0;
        while (phase !== 3'd4 && n < 100) begin
            @(negedge clk); n++;
            if (gimbal_enable) saw_gimbal = 1'b1;
        end
        checks++;
        if (phase !== 3'd4 || met_s !== 64'd5) begin
            errors++; $display("FAIL nominal_coast got phase=%0d met=%0d want phase=4 met=5",
                               phase, met_s);
        end
        checks++;
        if (saw_gimbal) begin
            errors++; $display("FAIL nominal_no_gimbal got gimbal seen=1 want 0");
        end
        checks++;
        if ({engine_on, start_integration, event_valid, event_code} !== 6'b011100) begin
            errors++; $display("FAIL nominal_coast_outputs got %b want 011100",
                               {engine_on, start_integration, event_valid, event_code});
        end
    endtask

    task automatic test_gimbal();
        int ev[$];
        int n, n_arm, n_gim;
        bit armed, gim_en;
        do_reset();
        height = 64'd0; burntime = 64'd10; launch_req = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        if (event_valid) ev.push_back(int'(event_code));
        n = 0; n_arm = -10; n_gim = -1; armed = 1'b0; gim_en = 1'b0;
        while (phase !== 3'd4 && n < 200) begin
            if (phase === 3'd2 && met_s === 64'd3 && !armed) begin
                height = 64'd100; armed = 1'b1; n_arm = n;
            end
            @(negedge clk); n++;
            if (event_valid) ev.push_back(int'(event_code));
            if (phase === 3'd3 && n_gim < 0) begin n_gim = n; gim_en = gimbal_enable; end
        end
        checks++;
        if (n_gim != n_arm + 1 || !gim_en) begin
            errors++; $display("FAIL gimbal_entry got lat=%0d en=%b want lat=1 en=1",
                               n_gim - n_arm, gim_en);
        end
        checks++;
        if (phase !== 3'd4 || met_s !== 64'd10) begin
            errors++; $display("FAIL gimbal_coast got phase=%0d met=%0d want phase=4 met=10",
                               phase, met_s);
        end
        checks++;
        if (ev.size() != 4 || ev[0] != 1 || ev[1] != 2 || ev[2] != 3 || ev[3] != 4) begin
            errors++; $display("FAIL gimbal_events got n=%0d %0d,%0d,%0d,%0d want 4 1,2,3,4",
                               ev.size(), ev[0], ev[1], ev[2], ev[3]);
        end
    endtask

    task automatic test_coincident();
        int n;
        do_reset();
        height = 64'd0; burntime = 64'd4; launch_req = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        n = 0;
        while (!(phase === 3'd2 && met_s === 64'd4) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL coincident_reach got phase=%0d met=%0d want phase=2 met=4",
                               phase, met_s);
        end
        height = 64'd100;
        @(negedge clk);
        checks++;
        if (phase !== 3'd4 || gimbal_enable !== 1'b0) begin
            errors++; $display("FAIL coincident_priority got phase=%0d gimbal=%b want 4 0",
                               phase, gimbal_enable);
        end
    endtask

    task automatic test_abort();
        int n;
        do_reset();
        height = 64'd100; burntime = 64'd10; launch_req = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        n = 0;
        while (!(phase === 3'd3 && met_s === 64'd4) && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL abort_reach got phase=%0d met=%0d want 3 4", phase, met_s);
        end
        abort = 1'b1;
        @(negedge clk);
        checks++;
        if ({phase, engine_on, start_integration, gimbal_enable, event_valid, event_code}
            !== {3'd5, 3'b000, 1'b1, 3'd5} || met_s !== 64'd4) begin
            errors++; $display("FAIL abort_safe got phase=%0d drv=%b ev=%b/%0d met=%0d want 5 000 1/5 4",
                               phase, {engine_on, start_integration, gimbal_enable},
                               event_valid, event_code, met_s);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (phase !== 3'd5 || met_s !== 64'd4 || sec_tick !== 1'b0) begin
            errors++; $display("FAIL abort_frozen got phase=%0d met=%0d tick=%b want 5 4 0",
                               phase, met_s, sec_tick);
        end
        abort = 1'b0; launch_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (phase !== 3'd5 || launch_ack !== 1'b0) begin
            errors++; $display("FAIL abort_hold_req got phase=%0d ack=%b want 5 0",
                               phase, launch_ack);
        end
        launch_req = 1'b0;
        @(negedge clk);
        checks++;
        if (phase !== 3'd0 || met_s !== 64'd0 || event_valid !== 1'b1) begin
            errors++; $display("FAIL abort_to_idle got phase=%0d met=%0d ev=%b want 0 0 1",
                               phase, met_s, event_valid);
        end
    endtask

    task automatic test_zero_burn();
        int acks, asc;
        do_reset();
        height = 64'd0; burntime = 64'd0; launch_req = 1'b1;
        acks = 0; asc = 0;
        repeat (20) begin
            @(negedge clk);
            if (launch_ack) acks++;
            if (phase === 3'd2) asc++;
        end
        checks++;
        if (acks != 1) begin
            errors++; $display("FAIL zero_burn_acks got %0d want 1", acks);
        end
        checks++;
        if (asc != 1 || phase !== 3'd4) begin
            errors++; $display("FAIL zero_burn_ascent got cycles=%0d phase=%0d want 1 4",
                               asc, phase);
        end
        launch_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        height = 64'd0; burntime = 64'd5; launch_req = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        n = 0;
        while (phase !== 3'd2 && n < 40) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        #3 resetb = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 12'd0 || met_s !== 64'd0) begin
            errors++; $display("FAIL async_reset got %b met=%0d want 0 0", dut_vec, met_s);
        end
        @(negedge clk);
        resetb = 1'b1;
        launch_req = 1'b1;
        @(negedge clk);
        launch_req = 1'b0;
        checks++;
        if (launch_ack !== 1'b1 || phase !== 3'd1) begin
            errors++; $display("FAIL relaunch_ack got ack=%b phase=%0d want 1 1",
                               launch_ack, phase);
        end
        n = 0;
        while (phase !== 3'd2 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (n != 8) begin
            errors++; $display("FAIL relaunch_latency got %0d want 8", n);
        end
        n = 0;
        while (phase !== 3'd4 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (met_s !== 64'd5 || phase !== 3'd4) begin
            errors++; $display("FAIL relaunch_coast got phase=%0d met=%0d want 4 5", phase, met_s);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random_outputs cycle %0d got %b want %b",
                                   i, dut_vec, exp_vec());
            end
            checks++;
            if (met_s !== m_met) begin
                errors++; $display("FAIL random_met cycle %0d got %0d want %0d", i, met_s, m_met);
            end
            abort      = ($urandom_range(0, 49) == 0);
            launch_req = ($urandom_range(0, 3) == 0);
            burntime   = 64'($urandom_range(0, 6));
            case ($urandom_range(0, 9))
                0:       height = 64'd100;
                1:       height = 64'd99;
                2:       height = {$urandom, $urandom};
                default: height = 64'($urandom_range(0, 98));
            endcase
            @(negedge clk);
        end
        abort = 1'b0; launch_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gimbal();
        test_coincident();
        test_abort();
        test_zero_burn();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
